// File: rtl/adder_feeder_pkg.sv
// ----------------------------------------------------------------------------
// adder_feeder_pkg : shared state encoding and sum-width derivation
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package adder_feeder_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    OUTPUT = 2'd3
  } feeder_state_e;

  // Shared by adder and feeder so both agree on the result width.
  function automatic int calc_res_width(input int width, input int dim);
    return width + `CLOG2(dim);
  endfunction

endpackage

`default_nettype wire

// File: rtl/adder_feeder_vector_packer.sv
// ----------------------------------------------------------------------------
// vector_packer : collects DIM serial elements into one packed vector
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vector_packer
  import adder_feeder_pkg::*;
#(
  parameter int DIM   = 2,
  parameter int WIDTH = 16
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   accept,
  output logic [DIM*WIDTH-1:0]   vector,
  output logic                   full
);

  localparam int IDX_W = `CLOG2(DIM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);

  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DIM*WIDTH-1:0] vector_q, vector_d;

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      idx_q    <= '0;
      vector_q <= '0;
    end else begin
      idx_q    <= idx_d;
      vector_q <= vector_d;
    end
  end

  always_comb begin
    vector_d = vector_q;
    idx_d    = idx_q;
    full     = accept && (idx_q == LAST_IDX);
    if (accept) begin
      for (int i = 0; i < DIM; i++) begin
        if (idx_q == IDX_W'(i)) vector_d[i*WIDTH +: WIDTH] = in_data;
      end
      idx_d = full ? '0 : idx_q + IDX_W'(1);
    end
  end

  assign vector = vector_q;

endmodule

`default_nettype wire

// File: rtl/adder_feeder.sv
// ----------------------------------------------------------------------------
// adder_feeder : packs a serial stream, drives the parallel adder, returns sum
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module adder_feeder
  import adder_feeder_pkg::*;
#(
  parameter int DIM       = 2,
  parameter int WIDTH     = 16,
  parameter int RES_WIDTH = calc_res_width(WIDTH, DIM),
  parameter int TIMEOUT   = 64
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DIM*WIDTH-1:0]  add_vector,
  output logic                  add_start,
  input  logic                  add_finished,
  input  logic [RES_WIDTH-1:0]  add_sum,
  output logic [RES_WIDTH-1:0]  out_sum,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  timeout_err,
  output logic                  busy
);

  localparam int CNT_W = `CLOG2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  feeder_state_e        state_q, state_d;
  logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [RES_WIDTH-1:0] out_sum_q, out_sum_d;
  logic                 out_valid_q, out_valid_d;
  logic                 timeout_err_q, timeout_err_d;
  logic                 vec_full;

  vector_packer #(
    .DIM   (DIM),
    .WIDTH (WIDTH)
  ) u_packer (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .in_data (in_data),
    .accept  (in_valid && in_ready),
    .vector  (add_vector),
    .full    (vec_full)
  );

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q       <= FILL;
      wait_cnt_q    <= '0;
      out_sum_q     <= '0;
      out_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      out_sum_q     <= out_sum_d;
      out_valid_q   <= out_valid_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // A finish in the same cycle as the last allowed wait cycle wins over timeout.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    out_sum_d     = out_sum_q;
    out_valid_d   = out_valid_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      FILL: begin
        if (vec_full) state_d = ISSUE;
      end
      ISSUE: begin
        state_d    = WAIT;
        wait_cnt_d = '0;
      end
      WAIT: begin
        if (add_finished) begin
          out_sum_d   = add_sum;
          out_valid_d = 1'b1;
          state_d     = OUTPUT;
        end else if (wait_cnt_q == CNT_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = FILL;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    in_ready    = (state_q == FILL);
    add_start   = (state_q == ISSUE);
    busy        = (state_q != FILL);
    out_sum     = out_sum_q;
    out_valid   = out_valid_q;
    timeout_err = timeout_err_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_adder_feeder.sv
// ----------------------------------------------------------------------------
// tb_adder_feeder : directed tests of adder_feeder against a small adder model
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_adder_feeder;

  localparam int DIM       = 2;
  localparam int WIDTH     = 16;
  localparam int RES_WIDTH = 17;
  localparam int TIMEOUT   = 8;

  logic                 Clock;
  logic                 Reset_n;
  logic [WIDTH-1:0]     in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [DIM*WIDTH-1:0] add_vector;
  logic                 add_start;
  logic                 add_finished;
  logic [RES_WIDTH-1:0] add_sum;
  logic [RES_WIDTH-1:0] out_sum;
  logic                 out_valid;
  logic                 out_ready;
  logic                 timeout_err;
  logic                 busy;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int ov_cnt = 0;
  bit model_en = 1'b1;
  int cd = 0;
  logic [RES_WIDTH-1:0] model_sum = '0;

  adder_feeder #(
    .DIM       (DIM),
    .WIDTH     (WIDTH),
    .RES_WIDTH (RES_WIDTH),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .add_vector   (add_vector),
    .add_start    (add_start),
    .add_finished (add_finished),
    .add_sum      (add_sum),
    .out_sum      (out_sum),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .timeout_err  (timeout_err),
    .busy         (busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Adder model: finished pulse three cycles after the start cycle.
  always @(negedge Clock) begin
    if (add_start && model_en) begin
      cd = 4;
      model_sum = {1'b0, add_vector[15:0]} + {1'b0, add_vector[31:16]};
    end else if (cd > 0) begin
      cd = cd - 1;
    end
    add_finished = (cd == 1);
    add_sum = model_sum;
  end

  always @(negedge Clock) begin
    if (add_start) start_cnt = start_cnt + 1;
    if (out_valid) ov_cnt = ov_cnt + 1;
  end

  task automatic send_pair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge Clock);
    in_valid = 1'b1;
    in_data  = a;
    @(negedge Clock);
    in_data  = b;
    @(negedge Clock);
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge Clock);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_out_valid: out_valid=0 after 20 cycles, required 1");
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (2) @(negedge Clock);
    Reset_n = 1'b1;
    checks++;
    if ({in_ready, busy, add_start, out_valid, timeout_err} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags: got rdy/busy/start/ov/err=%b required 10000",
               {in_ready, busy, add_start, out_valid, timeout_err});
    end
    checks++;
    if (add_vector !== 32'h0 || out_sum !== 17'h0) begin
      errors++;
      $display("FAIL reset_data: got vec=%h sum=%h required 0/0", add_vector, out_sum);
    end
  endtask

  task automatic test_basic();
    start_cnt = 0;
    ov_cnt = 0;
    out_ready = 1'b1;
    send_pair(16'h0008, 16'h0008);
    checks++;
    if (add_start !== 1'b1 || add_vector !== 32'h0008_0008 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_issue: got start=%b vec=%h rdy=%b required 1/00080008/0",
               add_start, add_vector, in_ready);
    end
    wait_out_valid();
    checks++;
    if (out_sum !== 17'd16) begin
      errors++;
      $display("FAIL basic_sum: got %0d required 16", out_sum);
    end
    @(negedge Clock);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_return: got ov=%b rdy=%b required 0/1", out_valid, in_ready);
    end
    checks++;
    if (start_cnt != 1 || ov_cnt != 1) begin
      errors++;
      $display("FAIL basic_pulses: got starts=%0d ov_cycles=%0d required 1/1", start_cnt, ov_cnt);
    end
  endtask

  task automatic test_max_values();
    send_pair(16'hFFFF, 16'hFFFF);
    wait_out_valid();
    checks++;
    if (out_sum !== 17'h1FFFE) begin
      errors++;
      $display("FAIL max_sum: got %h required 1fffe", out_sum);
    end
    @(negedge Clock);
  endtask

  task automatic test_backpressure();
    bit stable;
    out_ready = 1'b0;
    send_pair(16'd1, 16'd2);
    wait_out_valid();
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || out_sum !== 17'd3 || in_ready !== 1'b0) stable = 1'b0;
      @(negedge Clock);
    end
    checks++;
    if (!stable || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_hold: got ov=%b sum=%0d rdy=%b required 1/3/0 stable",
               out_valid, out_sum, in_ready);
    end
    out_ready = 1'b1;
    @(negedge Clock);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: got ov=%b rdy=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_gapped_input();
    start_cnt = 0;
    @(negedge Clock);
    in_valid = 1'b1;
    in_data  = 16'd3;
    @(negedge Clock);
    in_valid = 1'b0;
    in_data  = 16'hDEAD;
    @(negedge Clock);
    @(negedge Clock);
    in_valid = 1'b1;
    in_data  = 16'd5;
    @(negedge Clock);
    in_valid = 1'b0;
    checks++;
    if (add_start !== 1'b1 || add_vector !== 32'h0005_0003) begin
      errors++;
      $display("FAIL gapped_vector: got start=%b vec=%h required 1/00050003", add_start, add_vector);
    end
    wait_out_valid();
    checks++;
    if (out_sum !== 17'd8 || start_cnt != 1) begin
      errors++;
      $display("FAIL gapped_sum: got sum=%0d starts=%0d required 8/1", out_sum, start_cnt);
    end
    @(negedge Clock);
  endtask

  task automatic test_timeout();
    ov_cnt = 0;
    model_en = 1'b0;
    send_pair(16'd4, 16'd6);
    repeat (TIMEOUT) @(negedge Clock);
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: got err=%b busy=%b required 0/1", timeout_err, busy);
    end
    @(negedge Clock);
    checks++;
    if (timeout_err !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0 || ov_cnt != 0) begin
      errors++;
      $display("FAIL timeout_fire: got err=%b rdy=%b busy=%b ov_cycles=%0d required 1/1/0/0",
               timeout_err, in_ready, busy, ov_cnt);
    end
    model_en = 1'b1;
    send_pair(16'd1, 16'd2);
    wait_out_valid();
    checks++;
    if (out_sum !== 17'd3 || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_recover: got sum=%0d err=%b required 3/1", out_sum, timeout_err);
    end
    @(negedge Clock);
  endtask

  task automatic test_reset_mid_wait();
    send_pair(16'd10, 16'd20);
    @(negedge Clock);
    Reset_n = 1'b0;
    @(negedge Clock);
    Reset_n = 1'b1;
    ov_cnt = 0;
    checks++;
    if ({in_ready, busy, add_start, out_valid, timeout_err} !== 5'b10000 ||
        add_vector !== 32'h0 || out_sum !== 17'h0) begin
      errors++;
      $display("FAIL midwait_reset: got flags=%b vec=%h sum=%h required 10000/0/0",
               {in_ready, busy, add_start, out_valid, timeout_err}, add_vector, out_sum);
    end
    repeat (5) @(negedge Clock);
    checks++;
    if (ov_cnt != 0 || busy !== 1'b0 || out_sum !== 17'h0) begin
      errors++;
      $display("FAIL midwait_late_finish: got ov_cycles=%0d busy=%b sum=%h required 0/0/0",
               ov_cnt, busy, out_sum);
    end
    send_pair(16'd7, 16'd9);
    wait_out_valid();
    checks++;
    if (out_sum !== 17'd16) begin
      errors++;
      $display("FAIL midwait_next: got %0d required 16", out_sum);
    end
    @(negedge Clock);
  endtask

  initial begin
    Reset_n      = 1'b0;
    in_data      = '0;
    in_valid     = 1'b0;
    out_ready    = 1'b1;
    add_finished = 1'b0;
    add_sum      = '0;
    test_reset();
    test_basic();
    test_max_values();
    test_backpressure();
    test_gapped_input();
    test_timeout();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
